// File: rtl/washing_machine.sv
// ---------------------------------------------------------------------------
// washing_machine
//   Coin-operated wash-cycle controller. A coin in IDLE with the lid closed
//   starts a timed program SOAK -> WASH -> RINSE -> (optional extra
//   WASH/RINSE) -> SPIN -> DONE -> IDLE. An open lid freezes the program
//   in any timed state, for as long as the lid stays open.
//
// Ports
//   clk          system clock, rising-edge active
//   rst          asynchronous active-high reset (aborts any program)
//   coin         coin pulse, only honoured in IDLE with the lid closed
//   time_up      registered, high for the single DONE cycle
//   second_wash  level, requests one extra WASH+RINSE pass (sampled at
//                the RINSE expiry edge only)
//   lid_open     level, pauses the timed states while high
// ---------------------------------------------------------------------------
module washing_machine #(
  parameter int SOAK_CYC  = 3,
  parameter int WASH_CYC  = 4,
  parameter int RINSE_CYC = 3,
  parameter int SPIN_CYC  = 3,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic coin,
  output logic time_up,
  input  logic second_wash,
  input  logic lid_open
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SOAK  = 3'd1,
    WASH  = 3'd2,
    RINSE = 3'd3,
    SPIN  = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Timer reload values: each timed state counts load..0, so it lasts
  // exactly *_CYC unpaused cycles.
  localparam logic [CNT_W-1:0] SOAK_LD  = CNT_W'(SOAK_CYC - 1);
  localparam logic [CNT_W-1:0] WASH_LD  = CNT_W'(WASH_CYC - 1);
  localparam logic [CNT_W-1:0] RINSE_LD = CNT_W'(RINSE_CYC - 1);
  localparam logic [CNT_W-1:0] SPIN_LD  = CNT_W'(SPIN_CYC - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] timer, timer_next;
  logic             extra_done, extra_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      extra_done <= 1'b0;
      time_up    <= 1'b0;
    end else begin
      state      <= state_next;
      timer      <= timer_next;
      extra_done <= extra_next;
      // Registering the decode of the next state keeps time_up glitch-free
      // and aligned exactly with the cycle spent in DONE.
      time_up    <= (state_next == DONE);
    end
  end

  always_comb begin
    state_next = state;
    timer_next = timer;
    extra_next = extra_done;

    case (state)
      IDLE: begin
        if (coin && !lid_open) begin
          state_next = SOAK;
          timer_next = SOAK_LD;
        end
      end

      SOAK, WASH, RINSE, SPIN: begin
        // An open lid freezes both state and timer; nothing below runs.
        if (!lid_open) begin
          if (timer != '0) begin
            timer_next = timer - CNT_W'(1);
          end else begin
            case (state)
              SOAK: begin
                state_next = WASH;
                timer_next = WASH_LD;
              end
              WASH: begin
                state_next = RINSE;
                timer_next = RINSE_LD;
              end
              RINSE: begin
                // Only one extra pass per coin: extra_done blocks a repeat.
                if (second_wash && !extra_done) begin
                  state_next = WASH;
                  timer_next = WASH_LD;
                  extra_next = 1'b1;
                end else begin
                  state_next = SPIN;
                  timer_next = SPIN_LD;
                end
              end
              default: begin
                state_next = DONE;
                timer_next = '0;
              end
            endcase
          end
        end
      end

      DONE: begin
        state_next = IDLE;
        extra_next = 1'b0;
      end

      default: begin
        state_next = IDLE;
        timer_next = '0;
        extra_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_washing_machine.sv
// ---------------------------------------------------------------------------
// tb_washing_machine
//   Self-checking bench for washing_machine. A reference model counts the
//   active (unpaused) cycles of the running program and the program length
//   (13, or 20 once an extra pass is granted); time_up is expected exactly
//   when the count reaches the length. time_up is compared every cycle, and
//   directed runs also check the coin-to-time_up latency against fixed values.
// ---------------------------------------------------------------------------
module tb_washing_machine;

  localparam int S_CYC  = 3;
  localparam int W_CYC  = 4;
  localparam int R_CYC  = 3;
  localparam int SP_CYC = 3;

  logic clk;
  logic rst;
  logic coin;
  logic time_up;
  logic second_wash;
  logic lid_open;

  int n_checks = 0;
  int n_fail   = 0;

  washing_machine dut (
    .clk         (clk),
    .rst         (rst),
    .coin        (coin),
    .time_up     (time_up),
    .second_wash (second_wash),
    .lid_open    (lid_open)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: busy program, active-cycle count and program length.
  bit busy;
  int act;
  int total;
  bit extended;
  logic exp_time_up;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     = 1'b0;
      act      = 0;
      total    = 0;
      extended = 1'b0;
    end else if (!busy) begin
      if (coin && !lid_open) begin
        busy     = 1'b1;
        act      = 0;
        total    = S_CYC + W_CYC + R_CYC + SP_CYC;
        extended = 1'b0;
      end
    end else if (act == total) begin
      busy = 1'b0;
    end else if (!lid_open) begin
      act = act + 1;
      if (act == S_CYC + W_CYC + R_CYC && !extended && second_wash) begin
        extended = 1'b1;
        total    = total + W_CYC + R_CYC;
      end
    end
  end

  assign exp_time_up = busy && (act == total);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed,
               expected, $time);
    end
  endtask

  // Check time_up for the state after the previous edge, then drive the
  // inputs seen by the next rising edge.
  task automatic applyStimulus(input logic c, input logic l, input logic s);
    @(negedge clk);
    checkOutput("time_up", {31'd0, time_up}, {31'd0, exp_time_up});
    coin        = c;
    lid_open    = l;
    second_wash = s;
  endtask

  // Coin on edge E0, then edge k gets coin/lid/second_wash when k lies in the
  // given inclusive ranges. Returns the edge index at which time_up appeared.
  task automatic runCount(input int coin_lo, input int coin_hi,
                          input int lid_lo, input int lid_hi,
                          input int sw_lo, input int sw_hi,
                          output int edges);
    edges = -1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 60 && edges < 0; k++) begin
      applyStimulus(k >= coin_lo && k <= coin_hi, k >= lid_lo && k <= lid_hi,
                    k >= sw_lo && k <= sw_hi);
      if (time_up === 1'b1) edges = k - 1;
    end
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulseResetMidCycle(input string tag);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 checkOutput(tag, {31'd0, time_up}, 32'd0);
    #2 rst = 1'b0;
  endtask

  initial begin
    int edges;
    rst         = 1'b1;
    coin        = 1'b0;
    lid_open    = 1'b0;
    second_wash = 1'b0;
    #3 checkOutput("reset_time_up", {31'd0, time_up}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] basic run");
    runCount(0, 0, 0, 0, 0, 0, edges);
    checkOutput("basic_latency", edges, 13);

    $display("[TB] lid pause");
    runCount(0, 0, 10, 11, 0, 0, edges);
    checkOutput("lid_pause_latency", edges, 15);

    $display("[TB] second wash held through both rinses");
    runCount(0, 0, 0, 0, 1, 60, edges);
    checkOutput("second_wash_latency", edges, 20);

    $display("[TB] second wash requested while lid holds rinse expiry");
    runCount(0, 0, 9, 12, 1, 60, edges);
    checkOutput("paused_second_wash_latency", edges, 24);

    $display("[TB] coin with lid open in IDLE");
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (16) applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] coin pulses during WASH");
    runCount(4, 5, 0, 0, 0, 0, edges);
    checkOutput("coin_in_wash_latency", edges, 13);

    $display("[TB] late second wash during SPIN");
    runCount(0, 0, 0, 0, 11, 13, edges);
    checkOutput("late_second_wash_latency", edges, 13);

    $display("[TB] async reset in the extra WASH pass");
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (12) applyStimulus(1'b0, 1'b0, 1'b1);
    pulseResetMidCycle("reset_in_wash");
    runCount(0, 0, 0, 0, 1, 60, edges);
    checkOutput("after_reset_latency", edges, 20);

    $display("[TB] async reset while in DONE");
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (14) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("done_before_reset", {31'd0, time_up}, 32'd1);
    #1 rst = 1'b1;
    #1 checkOutput("reset_in_done", {31'd0, time_up}, 32'd0);
    #2 rst = 1'b0;
    repeat (16) applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                    1'($urandom_range(0, 1)));
    end
    repeat (30) applyStimulus(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks,
             n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at t=%0t, expected end", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
